regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer/float register file with per-register scoreboard, write bypass and multiple read/write ports. It is the next-generation register file for the core: it replaces the fixed 2-read/1-write/jr-port file with N read ports and M write ports. It also tracks pending (issued, not yet written back) destinations so the issue stage can stall on busy operands from multi-cycle FPU/memory units.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, registers per bank (power of two); RW = $clog2(NREG)
- NRP, 3, read ports (operand 1, operand 2, jr)
- NWP, 2, write ports (ALU, long-latency unit)

Ports (vectors flattened, port i occupies slice i):
- clk  in  1  clock
- rstn  in  1  reset; one clock, synchronous and active-low
- rfmode  in  NRP  per read port: 0 = integer bank, 1 = float bank
- rreg  in  NRP*RW  read addresses
- rdata  out  NRP*XLEN  read data
- rbusy  out  NRP  read register has a pending write
- iss_en  in  1  mark destination busy
- iss_fmode  in  1  bank of issued destination
- iss_reg  in  RW  issued destination
- wen  in  NWP  write enables
- wfmode  in  NWP  write bank per port
- wreg  in  NWP*RW  write addresses
- wdata  in  NWP*XLEN  write data
- busy_cnt  out  RW+2  number of busy registers across both banks

## Operation
- Two banks of NREG×XLEN flops; integer r0 reads 0 always; writes to it are dropped; it is never marked busy. Float f0 is an ordinary register.
- Reads combinational. Bypass: if any wen[j] targets the same bank/register as read port i this cycle, rdata[i] = wdata of the highest-index such j. Otherwise array contents.
- Write conflict (two ports, same bank/register, same cycle): highest-index port wins, for both the array and the bypass.
- Scoreboard: one busy bit per register per bank.
  - iss_en sets the bit at the clock edge.
  - Any wen clears the bit at the clock edge.
  - Same register issued and written in the same cycle: the bit ends set (old result retires, new one pending).
- rbusy[i] = busy bit of addressed register, with these overrides:
  - forced 0 if a same-cycle write targets it (data is bypassed);
  - forced 0 for r0;
  - not affected by a same-cycle issue.
- busy_cnt is registered. It equals the population count of all busy bits after the edge and is updated every cycle.
- Writing a non-busy register is legal (ALU writes): it updates data; the busy bit stays 0.

## Timing
- Read latency 0 (combinational); write and scoreboard update visible to reads the cycle after the edge. The bypass makes a write value visible in its own cycle.
- Reset (rstn=0 at an edge): all registers 0, all busy bits 0, busy_cnt 0. Reset dominates any simultaneous iss_en/wen. A reset mid-operation discards pending state, with no drain.
- rdata/rbusy during reset reflect the combinational path; they are defined as 0/0 from the cycle after the reset edge (ignoring bypass).
- No handshakes: issue and write ports are fire-and-forget each cycle the enable is high.

## Structure
- Shared package regfile_pkg: XLEN/NREG defaults, bank enum (BANK_INT=0, BANK_FLT=1), reg index type.
- One natural sub-module: regfile_bank (one bank: storage, NWP write ports with priority, bypass read mux, busy bits, zero_reg parameter). regfile_sb instantiates two banks and steers by mode; busy_cnt sums the two bank popcounts.

## Test plan
- Reset, then read all ports of both banks -> rdata=0, rbusy=0, busy_cnt=0.
- Write int r5=0xDEADBEEF on port 0 while reading r5 on port 1 -> rdata[1]=0xDEADBEEF the same cycle; next cycle the array holds it. Writes to r0=0x1234 -> reads 0.
- Issue f3, next cycle read f3 -> rbusy=1, busy_cnt=1; write f3=0x3F800000 on port 1 -> rbusy=0 and data bypassed that cycle; busy_cnt=0 next cycle.
- Same cycle: issue r7 and write r7=0x11 -> r7=0x11, busy bit set, busy_cnt=1.
- Both write ports target int r9 (0xAA, 0xBB) -> bypass and stored value 0xBB; int r9 and float f9 are independent.
- Issue r1, f2, r4; assert rstn=0 together with wen to r1 -> all busy cleared, r1=0, busy_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// bank selector encoding and register index type.
package regfile_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int RW_D   = $clog2(NREG_D);

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FLT = 1'b1
  } bank_e;

  typedef logic [RW_D-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_bank.sv
// One register bank: storage with prioritised write ports, same-cycle bypass
// read mux and per-register pending-write (busy) bits.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int NREG     = NREG_D,
  parameter int NRP      = 3,
  parameter int NWP      = 2,
  parameter bit ZERO_REG = 1'b0,
  localparam int RW      = $clog2(NREG)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NRP-1:0][RW-1:0]        rreg,
  output logic [NRP-1:0][XLEN-1:0]      rdata,
  output logic [NRP-1:0]                rbusy,
  input  logic                          iss_en,
  input  logic [RW-1:0]                 iss_reg,
  input  logic [NWP-1:0]                wen,
  input  logic [NWP-1:0][RW-1:0]        wreg,
  input  logic [NWP-1:0][XLEN-1:0]      wdata,
  output logic [RW:0]                   popcnt
);
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           busy, busy_nxt;

  // Retire clears first, then a new issue sets, so issue+write ends busy.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWP; j++)
      if (wen[j]) busy_nxt[wreg[j]] = 1'b0;
    if (iss_en) busy_nxt[iss_reg] = 1'b1;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    popcnt = '0;
    for (int k = 0; k < NREG; k++)
      popcnt = popcnt + (RW+1)'(busy_nxt[k]);
  end

  // Later ports are assigned last, so the highest index wins a conflict.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWP; j++)
        if (wen[j] && !(ZERO_REG && wreg[j] == '0))
          mem[wreg[j]] <= wdata[j];
      busy <= busy_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rdata[i] = mem[rreg[i]];
      rbusy[i] = busy[rreg[i]];
      if (!(ZERO_REG && rreg[i] == '0)) begin
        for (int j = 0; j < NWP; j++)
          if (wen[j] && wreg[j] == rreg[i]) begin
            rdata[i] = wdata[j];
            rbusy[i] = 1'b0;
          end
      end
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer/float register file with N read and M write ports, built from two
// banks steered by per-port mode; busy_cnt tracks pending destinations.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRP  = 3,
  parameter int NWP  = 2,
  localparam int RW  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NRP-1:0]        rfmode,
  input  logic [NRP*RW-1:0]     rreg,
  output logic [NRP*XLEN-1:0]   rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  iss_en,
  input  logic                  iss_fmode,
  input  logic [RW-1:0]         iss_reg,
  input  logic [NWP-1:0]        wen,
  input  logic [NWP-1:0]        wfmode,
  input  logic [NWP*RW-1:0]     wreg,
  input  logic [NWP*XLEN-1:0]   wdata,
  output logic [RW+1:0]         busy_cnt
);
  logic [NRP-1:0][RW-1:0]         rreg_a;
  logic [NWP-1:0][RW-1:0]         wreg_a;
  logic [NWP-1:0][XLEN-1:0]       wdata_a;
  logic [NRP-1:0][XLEN-1:0]       rdata_a;
  logic [1:0][NRP-1:0][XLEN-1:0]  bk_rdata;
  logic [1:0][NRP-1:0]            bk_rbusy;
  logic [1:0][RW:0]               bk_pop;

  assign rreg_a  = rreg;
  assign wreg_a  = wreg;
  assign wdata_a = wdata;
  assign rdata   = rdata_a;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam bit FM = (b == 1);
    regfile_bank #(
      .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP),
      .ZERO_REG(FM == bit'(BANK_INT))
    ) u_bank (
      .clk    (clk),
      .rstn   (rstn),
      .rreg   (rreg_a),
      .rdata  (bk_rdata[b]),
      .rbusy  (bk_rbusy[b]),
      .iss_en (iss_en && (iss_fmode == FM)),
      .iss_reg(iss_reg),
      .wen    (wen & (FM ? wfmode : ~wfmode)),
      .wreg   (wreg_a),
      .wdata  (wdata_a),
      .popcnt (bk_pop[b])
    );
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rdata_a[i] = bk_rdata[rfmode[i]][i];
      rbusy[i]   = bk_rbusy[rfmode[i]][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_cnt <= '0;
    else       busy_cnt <= (RW+2)'(bk_pop[0]) + (RW+2)'(bk_pop[1]);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, r0, scoreboard, write priority, reset.
module tb_regfile_sb;
  import regfile_pkg::*;
  localparam int XLEN = 32, NREG = 32, NRP = 3, NWP = 2, RW = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRP-1:0]      rfmode;
  logic [NRP*RW-1:0]   rreg;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                iss_en, iss_fmode;
  logic [RW-1:0]       iss_reg;
  logic [NWP-1:0]      wen, wfmode;
  logic [NWP*RW-1:0]   wreg;
  logic [NWP*XLEN-1:0] wdata;
  logic [RW+1:0]       busy_cnt;

  int ntest = 0, nfail = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk(clk), .rstn(rstn), .rfmode(rfmode), .rreg(rreg), .rdata(rdata),
    .rbusy(rbusy), .iss_en(iss_en), .iss_fmode(iss_fmode), .iss_reg(iss_reg),
    .wen(wen), .wfmode(wfmode), .wreg(wreg), .wdata(wdata), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd_port(input int i, input logic fm, input logic [RW-1:0] r);
    rfmode[i] = fm;
    rreg[i*RW +: RW] = r;
  endtask

  task automatic wr_port(input int j, input logic fm, input logic [RW-1:0] r,
                         input logic [XLEN-1:0] d);
    wen[j] = 1'b1;
    wfmode[j] = fm;
    wreg[j*RW +: RW] = r;
    wdata[j*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic fm, input logic [RW-1:0] r);
    iss_en = 1'b1; iss_fmode = fm; iss_reg = r;
  endtask

  task automatic idle();
    wen = '0; iss_en = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rd(input int i);
    return rdata[i*XLEN +: XLEN];
  endfunction

  initial begin
    rstn = 1'b0; rfmode = '0; rreg = '0; iss_en = 1'b0; iss_fmode = 1'b0;
    iss_reg = '0; wen = '0; wfmode = '0; wreg = '0; wdata = '0;
    tick(); tick();
    rstn = 1'b1;
    #1;
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);

    // Reset state across every register of both banks
    for (int r = 0; r < NREG; r++) begin
      rd_port(0, BANK_INT, RW'(r)); rd_port(1, BANK_FLT, RW'(r)); rd_port(2, BANK_FLT, RW'(r));
      #1;
      chk($sformatf("rst_rdata_r%0d", r), 64'(rdata), 64'd0);
      chk($sformatf("rst_rbusy_r%0d", r), 64'(rbusy), 64'd0);
    end

    // Bypass on int r5, then array holds it
    wr_port(0, BANK_INT, 5, 32'hDEADBEEF); rd_port(1, BANK_INT, 5); rd_port(0, BANK_FLT, 5);
    #1;
    chk("byp_r5", 64'(rd(1)), 64'hDEADBEEF);
    chk("byp_r5_rbusy", 64'(rbusy[1]), 64'd0);
    chk("byp_r5_flt_unaff", 64'(rd(0)), 64'd0);
    tick(); idle(); #1;
    chk("arr_r5", 64'(rd(1)), 64'hDEADBEEF);

    // r0 write dropped, no bypass
    wr_port(0, BANK_INT, 0, 32'h1234); rd_port(0, BANK_INT, 0);
    #1;
    chk("r0_byp", 64'(rd(0)), 64'd0);
    tick(); idle(); #1;
    chk("r0_arr", 64'(rd(0)), 64'd0);

    // Issue f3: busy not visible same cycle, visible next
    issue(BANK_FLT, 3); rd_port(2, BANK_FLT, 3); rd_port(0, BANK_INT, 3);
    #1;
    chk("f3_iss_same_cyc", 64'(rbusy[2]), 64'd0);
    tick(); idle(); #1;
    chk("f3_rbusy", 64'(rbusy[2]), 64'd1);
    chk("r3_int_not_busy", 64'(rbusy[0]), 64'd0);
    chk("f3_busy_cnt", 64'(busy_cnt), 64'd1);
    wr_port(1, BANK_FLT, 3, 32'h3F800000);
    #1;
    chk("f3_wr_rbusy", 64'(rbusy[2]), 64'd0);
    chk("f3_wr_byp", 64'(rd(2)), 64'h3F800000);
    chk("f3_wr_cnt_reg", 64'(busy_cnt), 64'd1);
    tick(); idle(); #1;
    chk("f3_cnt_clr", 64'(busy_cnt), 64'd0);
    chk("f3_arr", 64'(rd(2)), 64'h3F800000);
    chk("f3_rbusy_clr", 64'(rbusy[2]), 64'd0);

    // Issue and write r7 in the same cycle: ends busy with new data
    issue(BANK_INT, 7); wr_port(0, BANK_INT, 7, 32'h11); rd_port(0, BANK_INT, 7);
    tick(); idle(); #1;
    chk("r7_data", 64'(rd(0)), 64'h11);
    chk("r7_rbusy", 64'(rbusy[0]), 64'd1);
    chk("r7_cnt", 64'(busy_cnt), 64'd1);
    wr_port(1, BANK_INT, 7, 32'h22);
    tick(); idle(); #1;
    chk("r7_retire_cnt", 64'(busy_cnt), 64'd0);
    chk("r7_retire_data", 64'(rd(0)), 64'h22);

    // r0 is never marked busy
    issue(BANK_INT, 0); rd_port(0, BANK_INT, 0);
    tick(); idle(); #1;
    chk("r0_iss_cnt", 64'(busy_cnt), 64'd0);
    chk("r0_iss_rbusy", 64'(rbusy[0]), 64'd0);

    // Write conflict on int r9: port 1 wins; f9 independent
    wr_port(0, BANK_INT, 9, 32'hAA); wr_port(1, BANK_INT, 9, 32'hBB);
    rd_port(0, BANK_INT, 9); rd_port(1, BANK_FLT, 9);
    #1;
    chk("r9_byp_prio", 64'(rd(0)), 64'hBB);
    chk("f9_byp_indep", 64'(rd(1)), 64'd0);
    tick(); idle(); #1;
    chk("r9_arr_prio", 64'(rd(0)), 64'hBB);
    chk("f9_arr_indep", 64'(rd(1)), 64'd0);
    wr_port(0, BANK_FLT, 9, 32'hCC); wr_port(1, BANK_FLT, 0, 32'h77);
    tick(); idle(); rd_port(2, BANK_FLT, 0); #1;
    chk("r9_after_f9", 64'(rd(0)), 64'hBB);
    chk("f9_data", 64'(rd(1)), 64'hCC);
    chk("f0_ordinary", 64'(rd(2)), 64'h77);

    // Build up pending state, then reset with a simultaneous write and issue
    issue(BANK_INT, 1); tick();
    issue(BANK_FLT, 2); tick();
    issue(BANK_INT, 4); tick();
    issue(BANK_FLT, 0); tick(); idle();
    rd_port(0, BANK_INT, 1); rd_port(1, BANK_FLT, 2); rd_port(2, BANK_FLT, 0);
    #1;
    chk("multi_cnt", 64'(busy_cnt), 64'd4);
    chk("multi_rbusy", 64'(rbusy), 64'b111);
    rstn = 1'b0;
    wr_port(0, BANK_INT, 1, 32'h55); issue(BANK_INT, 5);
    tick(); idle(); rstn = 1'b1; #1;
    chk("rst2_cnt", 64'(busy_cnt), 64'd0);
    chk("rst2_rbusy", 64'(rbusy), 64'd0);
    chk("rst2_r1", 64'(rd(0)), 64'd0);
    chk("rst2_f0", 64'(rd(2)), 64'd0);
    rd_port(0, BANK_INT, 5); rd_port(1, BANK_FLT, 3); rd_port(2, BANK_INT, 9);
    #1;
    chk("rst2_data", 64'(rdata), 64'd0);
    chk("rst2_rbusy_r5", 64'(rbusy[0]), 64'd0);
    tick();
    chk("rst2_cnt_hold", 64'(busy_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
